// File: rtl/sel_arb_pkg.sv
// rtl/sel_arb_pkg.sv - shared constants, state type and one-hot helper for sel_rr_arbiter
package sel_arb_pkg;

    localparam int NUM_CH = 6;
    localparam int SEL_W  = 3;
    localparam logic [SEL_W-1:0] IDLE_SEL = 3'd7;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    function automatic logic [NUM_CH-1:0] onehot_ch(input logic [SEL_W-1:0] idx);
        return NUM_CH'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick: first set request at or after ptr, wrapping modulo NUM_CH
module rr_pick
    import sel_arb_pkg::*;
(
    input  logic [NUM_CH-1:0] req_masked,
    input  logic [SEL_W-1:0]  ptr,
    output logic              found,
    output logic [SEL_W-1:0]  idx
);

    localparam logic [SEL_W:0] NUM_CH_X = (SEL_W+1)'(NUM_CH);

    logic [NUM_CH-1:0] rot;
    logic [SEL_W-1:0]  off;
    logic [SEL_W:0]    sum;

    // Rotate the doubled vector so ptr lands on bit 0, priority-encode, then undo the rotation.
    always_comb begin
        rot   = NUM_CH'({req_masked, req_masked} >> ptr);
        found = |rot;
        off   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = SEL_W'(i);
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= NUM_CH_X) begin
            sum = sum - NUM_CH_X;
        end
        idx = sum[SEL_W-1:0];
    end

endmodule

// File: rtl/sel_rr_arbiter.sv
// rtl/sel_rr_arbiter.sv - round-robin sel arbiter with valid/ready handshake; SEL_ARB_HIPRI0_EN makes channel 0 strict priority
module sel_rr_arbiter
    import sel_arb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] req,
    input  logic              out_ready,
    output logic [SEL_W-1:0]  sel,
    output logic              out_valid,
    output logic [NUM_CH-1:0] gnt,
    output logic              busy
);

    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

    arb_state_t        state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic              valid_q, valid_d;
    logic              transfer;
    logic [NUM_CH-1:0] pick_req;
    logic [SEL_W-1:0]  pick_ptr;
    logic              pick_found;
    logic [SEL_W-1:0]  pick_idx;
    logic [SEL_W-1:0]  win_idx;

    assign transfer = valid_q & out_ready;

    // Build the arbitration inputs: in GRANT the completing source is masked and the advanced ptr is used.
    always_comb begin
        ptr_d    = ptr_q;
        pick_req = req;
        pick_ptr = ptr_q;
        if (state_q == GRANT) begin
            pick_req = req & ~onehot_ch(sel_q);
            if (transfer) begin
                ptr_d = (sel_q == LAST_CH) ? '0 : sel_q + 1'b1;
`ifdef SEL_ARB_HIPRI0_EN
                if (sel_q == '0) begin
                    ptr_d = ptr_q;
                end
`endif
            end
            pick_ptr = ptr_d;
        end
    end

    rr_pick u_rr_pick (
        .req_masked (pick_req),
        .ptr        (pick_ptr),
        .found      (pick_found),
        .idx        (pick_idx)
    );

`ifdef SEL_ARB_HIPRI0_EN
    assign win_idx = pick_req[0] ? '0 : pick_idx;
`else
    assign win_idx = pick_idx;
`endif

    // Next-state logic: grant on any request from IDLE, hold while pending, re-arbitrate on transfer.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    sel_d   = win_idx;
                    valid_d = 1'b1;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (transfer) begin
                    if (pick_found) begin
                        sel_d = win_idx;
                    end else begin
                        sel_d   = IDLE_SEL;
                        valid_d = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                sel_d   = IDLE_SEL;
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State, select, valid and round-robin pointer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sel_q   <= IDLE_SEL;
            valid_q <= 1'b0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

    assign sel       = sel_q;
    assign out_valid = valid_q;
    assign busy      = (state_q == GRANT);
    assign gnt       = (transfer && !reset) ? onehot_ch(sel_q) : '0;

endmodule

// File: tb/tb_sel_rr_arbiter.sv
// tb/tb_sel_rr_arbiter.sv - directed and model-checked bench for sel_rr_arbiter
module tb_sel_rr_arbiter;
    import sel_arb_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic [NUM_CH-1:0] req;
    logic              out_ready;
    logic [SEL_W-1:0]  sel;
    logic              out_valid;
    logic [NUM_CH-1:0] gnt;
    logic              busy;

    int n_total = 0;
    int n_pass  = 0;

    sel_rr_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .out_ready (out_ready),
        .sel       (sel),
        .out_valid (out_valid),
        .gnt       (gnt),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_total++;
        if (obs !== want) begin
            $display("FAIL %s: got %0h want %0h", tag, obs, want);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [NUM_CH-1:0] r, input logic rdy);
        req       = r;
        out_ready = rdy;
        #1;
    endtask

    task automatic exp_out(input string tag, input logic [SEL_W-1:0] s, input logic v,
                           input logic [NUM_CH-1:0] g);
        check({tag, ".sel"}, 32'(sel), 32'(s));
        check({tag, ".valid"}, 32'(out_valid), 32'(v));
        check({tag, ".gnt"}, 32'(gnt), 32'(g));
    endtask

    function automatic int mpick(input logic [NUM_CH-1:0] r, input int p);
        for (int k = 0; k < NUM_CH; k++) begin
            int c;
            c = (p + k) % NUM_CH;
            if (r[c]) return c;
        end
        return 7;
    endfunction

    initial begin
        logic [NUM_CH-1:0] r;
        logic [NUM_CH-1:0] mr;
        logic [NUM_CH-1:0] g;
        logic              rdy;
        int                m_sel;
        int                m_ptr;
        logic              m_valid;

        reset     = 1'b1;
        req       = '0;
        out_ready = 1'b0;
        tick();
        tick();
        exp_out("rst", 3'd7, 1'b0, 6'b0);
        check("rst.busy", 32'(busy), 32'd0);
        reset = 1'b0;

        // single request, 1-cycle latency, immediate transfer
        drive(6'b000100, 1'b1);
        exp_out("t1.idle", 3'd7, 1'b0, 6'b0);
        tick();
        drive(6'b000100, 1'b1);
        exp_out("t1.grant", 3'd2, 1'b1, 6'b000100);
        check("t1.busy", 32'(busy), 32'd1);
        tick();
        drive(6'b0, 1'b1);
        exp_out("t1.done", 3'd7, 1'b0, 6'b0);
        check("t1.busy0", 32'(busy), 32'd0);

        // all requesting, back-to-back rotation 0..5,0
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(6'b111111, 1'b1);
        tick();
        for (int k = 0; k <= NUM_CH; k++) begin
            if (k == 0) r = 6'b111111;
            else        r = ~(NUM_CH'(1) << ((k - 1) % NUM_CH));
            drive(r, 1'b1);
            exp_out($sformatf("t2.k%0d", k), SEL_W'(k % NUM_CH), 1'b1, NUM_CH'(1) << (k % NUM_CH));
            tick();
        end

        // ptr=5 with stall, then wrap to channel 0
        reset = 1'b1;
        drive(6'b0, 1'b0);
        tick();
        reset = 1'b0;
        drive(6'b010000, 1'b1);
        tick();
        drive(6'b010000, 1'b1);
        exp_out("t3.c4", 3'd4, 1'b1, 6'b010000);
        tick();
        drive(6'b100001, 1'b0);
        exp_out("t3.idle", 3'd7, 1'b0, 6'b0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(6'b100001, 1'b0);
            exp_out($sformatf("t3.hold%0d", i), 3'd5, 1'b1, 6'b0);
            tick();
        end
        drive(6'b100001, 1'b1);
        exp_out("t3.x5", 3'd5, 1'b1, 6'b100000);
        tick();
        drive(6'b000001, 1'b1);
        exp_out("t3.wrap", 3'd0, 1'b1, 6'b000001);
        tick();
        drive(6'b0, 1'b0);
        exp_out("t3.end", 3'd7, 1'b0, 6'b0);

        // reset mid-GRANT abandons the word and clears ptr (ptr is 1 here)
        drive(6'b001000, 1'b0);
        tick();
        drive(6'b001000, 1'b0);
        exp_out("t4.pend", 3'd3, 1'b1, 6'b0);
        reset = 1'b1;
        drive(6'b001000, 1'b1);
        check("t4.rst_gnt", 32'(gnt), 32'd0);
        tick();
        reset = 1'b0;
        drive(6'b001001, 1'b1);
        exp_out("t4.after", 3'd7, 1'b0, 6'b0);
        tick();
        drive(6'b001001, 1'b1);
        exp_out("t4.ptr0", 3'd0, 1'b1, 6'b000001);
        tick();

        // random traffic against a behavioural model
        reset = 1'b1;
        drive(6'b0, 1'b0);
        tick();
        reset   = 1'b0;
        m_sel   = 7;
        m_ptr   = 0;
        m_valid = 1'b0;
        for (int n = 0; n < 300; n++) begin
            r   = NUM_CH'($urandom_range(0, 63));
            rdy = 1'($urandom_range(0, 1));
            drive(r, rdy);
            g = (m_valid && rdy) ? (NUM_CH'(1) << m_sel) : '0;
            exp_out($sformatf("rnd%0d", n), SEL_W'(m_sel), m_valid, g);
            if (m_valid) begin
                if (rdy) begin
                    m_ptr = (m_sel == NUM_CH - 1) ? 0 : m_sel + 1;
                    mr    = r & ~(NUM_CH'(1) << m_sel);
                    if (mr != '0) begin
                        m_sel = mpick(mr, m_ptr);
                    end else begin
                        m_sel   = 7;
                        m_valid = 1'b0;
                    end
                end
            end else if (r != '0) begin
                m_sel   = mpick(r, m_ptr);
                m_valid = 1'b1;
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
